// File: rtl/chan_err_pkg.sv
// Shared types, LFSR polynomial and helpers for the noisy-channel error injector.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } chan_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } chan_state_e;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] popcount(input logic [31:0] v);
    logic [15:0] n;
    n = 16'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {15'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Galois LFSR that advances one step per asserted step_i.
module chan_lfsr16
  import chan_err_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/channel_error_injector.sv
// Noisy-channel model: registers each symbol and XORs err_mask_i onto it per mode.
// Define CHAN_ERR_BIT_STATS_EN to enable the flipped-bit counter (tied 0 otherwise).
module channel_error_injector
  import chan_err_pkg::*;
#(
  parameter int          W           = 2,
  parameter int          PERIOD_LOG2 = 4,
  parameter int          BURST_LEN   = 2,
  parameter int          WINDOW      = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode_i,
  input  logic [W-1:0] err_mask_i,
  input  logic [3:0]   rate_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         err_inj_o,
  output logic         window_done_o,
  output logic [15:0]  inj_count_o,
  output logic [15:0]  bad_bit_count_o
);

  localparam int SCW = $clog2(WINDOW + 1);
  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam logic [SCW-1:0]         LAST_SYM   = SCW'(WINDOW - 1);
  localparam logic [BCW-1:0]         BURST_LAST = BCW'(BURST_LEN - 1);
  localparam logic [PERIOD_LOG2-1:0] PER_THRESH = PERIOD_LOG2'(2**PERIOD_LOG2 - BURST_LEN);

  chan_state_e    state_q, state_d;
  chan_mode_e     mode_q, mode_d;
  chan_mode_e     eff_mode;
  logic [SCW-1:0] sym_ct_q, sym_ct_d;
  logic [BCW-1:0] burst_ct_q, burst_ct_d;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           err_inj_q, err_inj_d;
  logic [15:0]    inj_count_q, inj_count_d;
  logic           trigger;
  logic           inject;
  logic           clear;
  logic [15:0]    lfsr_w;
  logic           unused_lfsr_hi;

  chan_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step_i(in_valid_i),
    .lfsr_o(lfsr_w)
  );

  assign unused_lfsr_hi = ^lfsr_w[15:4];

  // A valid symbol arriving in IDLE with a non-OFF mode is already the first
  // eligible symbol of the window, so the mode is applied to it directly.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    eff_mode    = mode_q;
    sym_ct_d    = sym_ct_q;
    burst_ct_d  = burst_ct_q;
    out_data_d  = out_data_q;
    err_inj_d   = 1'b0;
    inj_count_d = inj_count_q;
    inject      = 1'b0;
    clear       = 1'b0;
    trigger     = (lfsr_w[3:0] < rate_i);

    if (in_valid_i) begin
      out_data_d = in_data_i;
    end

    if (chan_mode_e'(mode_i) == MODE_OFF) begin
      clear       = 1'b1;
      state_d     = S_IDLE;
      sym_ct_d    = '0;
      burst_ct_d  = '0;
      inj_count_d = 16'd0;
    end else if (in_valid_i && (state_q != S_DONE)) begin
      if (state_q == S_IDLE) begin
        eff_mode = chan_mode_e'(mode_i);
        mode_d   = chan_mode_e'(mode_i);
      end

      case (eff_mode)
        MODE_PERIODIC: inject = (sym_ct_q[PERIOD_LOG2-1:0] >= PER_THRESH);
        MODE_BURST:    inject = (state_q == S_BURST) || trigger;
        MODE_RANDOM:   inject = trigger;
        default:       inject = 1'b0;
      endcase

      state_d = S_RUN;
      if ((eff_mode == MODE_BURST) && inject) begin
        if (burst_ct_q == BURST_LAST) begin
          burst_ct_d = '0;
        end else begin
          burst_ct_d = burst_ct_q + BCW'(1);
          state_d    = S_BURST;
        end
      end

      // Window end wins over an unfinished burst.
      if (sym_ct_q == LAST_SYM) begin
        state_d    = S_DONE;
        burst_ct_d = '0;
      end
      sym_ct_d = sym_ct_q + SCW'(1);

      if (inject) begin
        out_data_d  = in_data_i ^ err_mask_i;
        err_inj_d   = 1'b1;
        inj_count_d = (inj_count_q == 16'hFFFF) ? inj_count_q : inj_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_OFF;
      sym_ct_q    <= '0;
      burst_ct_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_inj_q   <= 1'b0;
      inj_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sym_ct_q    <= sym_ct_d;
      burst_ct_q  <= burst_ct_d;
      out_valid_q <= in_valid_i;
      out_data_q  <= out_data_d;
      err_inj_q   <= err_inj_d;
      inj_count_q <= inj_count_d;
    end
  end

`ifdef CHAN_ERR_BIT_STATS_EN
  logic [15:0] bad_q, bad_d;
  logic [16:0] bad_sum;

  always_comb begin
    bad_sum = {1'b0, bad_q} + {1'b0, popcount(32'(in_data_i ^ out_data_d))};
    bad_d   = bad_q;
    if (clear) begin
      bad_d = 16'd0;
    end else if (inject) begin
      bad_d = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q <= 16'd0;
    end else begin
      bad_q <= bad_d;
    end
  end

  assign bad_bit_count_o = bad_q;
`else
  assign bad_bit_count_o = 16'd0;
`endif

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign err_inj_o     = err_inj_q;
  assign window_done_o = (state_q == S_DONE);
  assign inj_count_o   = inj_count_q;

endmodule
